dlsc_pcie_tlp_arbiter: RTL

Merges up to PORTS independent 32-bit TLP streams onto one outbound TLP stream, feeding the PCIe transmit path or a downstream TLP preprocessor. Each grant is held for one whole TLP, from the first beat through the beat with `last`. Round-robin fairness applies between TLPs. A single registered output stage isolates the downstream `ready` from the requester selection.

---
 rtl/dlsc_pcie_pkg.sv | 11 +
 rtl/dlsc_pcie_tlp_arbiter_if.sv | 35 +++
 rtl/dlsc_rr_select.sv | 30 +++
 rtl/dlsc_pcie_tlp_arbiter.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/dlsc_pcie_pkg.sv
// Shared PCIe TLP definitions: beat width and the arbiter FSM state encoding.
package dlsc_pcie_pkg;

    localparam int unsigned TlpDataWidth = 32;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StBusy = 1'b1
    } arb_state_e;

endpackage

// File: rtl/dlsc_pcie_tlp_arbiter_if.sv
// Bundle of the per-requester TLP inputs and the merged TLP output stream.
interface dlsc_pcie_tlp_arbiter_if #(
    parameter int unsigned PORTS      = 4,
    parameter int unsigned USER_WIDTH = 7,
    parameter int unsigned SRC_WIDTH  = 2
);
    import dlsc_pcie_pkg::*;

    logic [PORTS-1:0]              in_ready;
    logic [PORTS-1:0]              in_valid;
    logic [PORTS-1:0]              in_last;
    logic [PORTS*TlpDataWidth-1:0] in_data;
    logic [PORTS*USER_WIDTH-1:0]   in_user;

    logic                          out_ready;
    logic                          out_valid;
    logic                          out_last;
    logic [TlpDataWidth-1:0]       out_data;
    logic [USER_WIDTH-1:0]         out_user;
    logic [SRC_WIDTH-1:0]          out_src;
    logic                          out_sop;

    // Arbiter side.
    modport master (
        output in_ready, out_valid, out_last, out_data, out_user, out_src, out_sop,
        input  in_valid, in_last, in_data, in_user, out_ready
    );

    // Requester / downstream side.
    modport slave (
        input  in_ready, out_valid, out_last, out_data, out_user, out_src, out_sop,
        output in_valid, in_last, in_data, in_user, out_ready
    );

endinterface

// File: rtl/dlsc_rr_select.sv
// Combinational rotate-priority encoder: first set request strictly after rr_ptr, with wrap.
module dlsc_rr_select #(
    parameter int unsigned PORTS     = 4,
    parameter int unsigned SRC_WIDTH = 2
) (
    input  logic [PORTS-1:0]     req,
    input  logic [SRC_WIDTH-1:0] rr_ptr,
    output logic [PORTS-1:0]     onehot,
    output logic [SRC_WIDTH-1:0] idx,
    output logic                 any
);

    always_comb begin
        int p;
        p      = 0;
        onehot = '0;
        idx    = '0;
        any    = |req;
        // Walk from the farthest candidate back to rr_ptr+1 so the nearest one wins last.
        for (int k = int'(PORTS); k >= 1; k--) begin
            p = (int'(rr_ptr) + k) % int'(PORTS);
            if (req[p]) begin
                onehot    = '0;
                onehot[p] = 1'b1;
                idx       = SRC_WIDTH'(p);
            end
        end
    end

endmodule

// File: rtl/dlsc_pcie_tlp_arbiter.sv
// Round-robin TLP arbiter: holds a grant for a whole TLP, registered output stage.
// Optional DLSC_PCIE_TLP_ARBITER_STRICT0_EN gives requester 0 absolute priority in IDLE.
module dlsc_pcie_tlp_arbiter
    import dlsc_pcie_pkg::*;
#(
    parameter int unsigned PORTS      = 4,
    parameter int unsigned USER_WIDTH = 7,
    parameter int unsigned SRC_WIDTH  = 2
) (
    input logic                     clk,
    input logic                     rst_n,
    dlsc_pcie_tlp_arbiter_if.master bus
);

    arb_state_e             state_q, state_d;
    logic [SRC_WIDTH-1:0]   grant_q, grant_d;
    logic [PORTS-1:0]       grant_oh_q, grant_oh_d;
    logic [SRC_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
    logic                   first_q, first_d;

    logic [PORTS-1:0]       sel_req, sel_onehot;
    logic [SRC_WIDTH-1:0]   sel_idx;
    logic                   sel_any;

    logic                   win_any;
    logic [PORTS-1:0]       win_oh;
    logic [SRC_WIDTH-1:0]   win_idx;

    logic [PORTS-1:0]       in_ready;
    logic                   accept;
    logic                   beat_last;
    logic [TlpDataWidth-1:0] beat_data;
    logic [USER_WIDTH-1:0]  beat_user;

    logic                   out_valid_q;
    logic                   out_last_q;
    logic                   out_sop_q;
    logic [TlpDataWidth-1:0] out_data_q;
    logic [USER_WIDTH-1:0]  out_user_q;
    logic [SRC_WIDTH-1:0]   out_src_q;

`ifdef DLSC_PCIE_TLP_ARBITER_STRICT0_EN
    // Requester 0 is handled outside the rotation.
    assign sel_req = bus.in_valid & ~PORTS'(1);
`else
    assign sel_req = bus.in_valid;
`endif

    dlsc_rr_select #(
        .PORTS     (PORTS),
        .SRC_WIDTH (SRC_WIDTH)
    ) u_rr_select (
        .req    (sel_req),
        .rr_ptr (rr_ptr_q),
        .onehot (sel_onehot),
        .idx    (sel_idx),
        .any    (sel_any)
    );

    always_comb begin
        win_any = sel_any;
        win_oh  = sel_onehot;
        win_idx = sel_idx;
`ifdef DLSC_PCIE_TLP_ARBITER_STRICT0_EN
        if (bus.in_valid[0]) begin
            win_any = 1'b1;
            win_oh  = PORTS'(1);
            win_idx = '0;
        end
`endif
    end

    // Beat mux from the granted requester.
    always_comb begin
        beat_data = '0;
        beat_user = '0;
        beat_last = 1'b0;
        for (int i = 0; i < int'(PORTS); i++) begin
            if (grant_oh_q[i]) begin
                beat_data = bus.in_data[i*TlpDataWidth +: TlpDataWidth];
                beat_user = bus.in_user[i*USER_WIDTH +: USER_WIDTH];
                beat_last = bus.in_last[i];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        grant_oh_d = grant_oh_q;
        rr_ptr_d   = rr_ptr_q;
        first_d    = first_q;
        in_ready   = '0;
        accept     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (win_any) begin
                    grant_d    = win_idx;
                    grant_oh_d = win_oh;
                    first_d    = 1'b1;
                    state_d    = StBusy;
                end
            end
            StBusy: begin
                in_ready = grant_oh_q & {PORTS{!out_valid_q || bus.out_ready}};
                accept   = |(in_ready & bus.in_valid);
                if (accept) begin
                    first_d = 1'b0;
                    if (beat_last) begin
                        state_d = StIdle;
`ifdef DLSC_PCIE_TLP_ARBITER_STRICT0_EN
                        if (grant_q != '0) rr_ptr_d = grant_q;
`else
                        rr_ptr_d = grant_q;
`endif
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            grant_q    <= '0;
            grant_oh_q <= '0;
            rr_ptr_q   <= SRC_WIDTH'(PORTS - 1);
            first_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_oh_q <= grant_oh_d;
            rr_ptr_q   <= rr_ptr_d;
            first_q    <= first_d;
        end
    end

    // Output stage: a load wins over a drain in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_sop_q   <= 1'b0;
            out_data_q  <= '0;
            out_user_q  <= '0;
            out_src_q   <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_last_q  <= beat_last;
            out_sop_q   <= first_q;
            out_data_q  <= beat_data;
            out_user_q  <= beat_user;
            out_src_q   <= grant_q;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_sop   = out_sop_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_user  = out_user_q;
    assign bus.out_src   = out_src_q;

endmodule
